// File: rtl/handshake_rr_arbiter_if.sv
// Handshake bundle for handshake_rr_arbiter: the downstream req/ack/data
// fan-out and the single upstream req/ack/data channel.
// master: the arbiter side. slave: the requesters plus the upstream producer.
interface handshake_rr_arbiter_if #(
  parameter int data_width = 32,
  parameter int num_req    = 4
);
  logic [num_req-1:0]    dn_req;
  logic [num_req-1:0]    dn_ack;
  logic [data_width-1:0] dn_dout;
  logic                  up_req;
  logic                  up_ack;
  logic [data_width-1:0] up_din;

  modport master (
    input  dn_req,
    output dn_ack,
    output dn_dout,
    output up_req,
    input  up_ack,
    input  up_din
  );

  modport slave (
    output dn_req,
    input  dn_ack,
    input  dn_dout,
    input  up_req,
    output up_ack,
    output up_din
  );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter: shares one upstream req/ack data channel among
// num_req downstream requesters, one granted transaction at a time, with
// round-robin priority. Each transaction is IDLE -> WAIT -> DELIVER.
// Optional feature: define ARB_STATS_EN to get per-requester 32-bit grant
// counters on grant_count; otherwise grant_count is constant zero.
module handshake_rr_arbiter #(
  parameter  int data_width = 32,
  parameter  int num_req    = 4,
  localparam int idx_width  = $clog2(num_req)
) (
  input  logic                    clk,
  input  logic                    rst,
  handshake_rr_arbiter_if.master  bus,
  output logic [idx_width-1:0]    grant_idx,
  output logic                    busy,
  output logic [num_req*32-1:0]   grant_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [idx_width-1:0]  grant_idx_q, grant_idx_nxt;
  logic [idx_width-1:0]  last_grant, last_grant_nxt;
  logic                  up_req_q, up_req_nxt;
  logic [num_req-1:0]    dn_ack_q, dn_ack_nxt;
  logic [data_width-1:0] dn_dout_q, dn_dout_nxt;
  logic                  busy_q, busy_nxt;

  logic                  pick_found;
  logic [idx_width-1:0]  pick_idx;
  logic [idx_width-1:0]  cand;

  // Index that is k positions after base, wrapping modulo num_req.
  function automatic logic [idx_width-1:0] wrap_idx(
    input logic [idx_width-1:0] base,
    input int                   k
  );
    int pos;
    pos = int'(base) + k;
    if (pos >= num_req) pos = pos - num_req;
    return idx_width'(pos);
  endfunction

  // Round-robin pick: first requester with req set, starting after last_grant.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = last_grant;
    cand       = '0;
    for (int k = 1; k <= num_req; k++) begin
      cand = wrap_idx(last_grant, k);
      if (!pick_found && bus.dn_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_idx_q <= '0;
      last_grant  <= idx_width'(num_req - 1);
      up_req_q    <= 1'b0;
      dn_ack_q    <= '0;
      dn_dout_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state       <= state_nxt;
      grant_idx_q <= grant_idx_nxt;
      last_grant  <= last_grant_nxt;
      up_req_q    <= up_req_nxt;
      dn_ack_q    <= dn_ack_nxt;
      dn_dout_q   <= dn_dout_nxt;
      busy_q      <= busy_nxt;
    end
  end

  // Next-state logic: arbitrate only in IDLE; DELIVER always returns to IDLE
  // so the served requester has one cycle to drop its req.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = WAIT;
      WAIT:    if (bus.up_ack) state_nxt = DELIVER;
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the grant pointer.
  always_comb begin
    grant_idx_nxt  = grant_idx_q;
    last_grant_nxt = last_grant;
    up_req_nxt     = up_req_q;
    dn_dout_nxt    = dn_dout_q;
    dn_ack_nxt     = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_idx_nxt = pick_idx;
          up_req_nxt    = 1'b1;
        end
      end
      WAIT: begin
        // up_ack and up_din are only looked at here, so a late or lingering
        // upstream ack outside WAIT can never produce a delivery.
        if (bus.up_ack) begin
          dn_dout_nxt             = bus.up_din;
          up_req_nxt              = 1'b0;
          dn_ack_nxt[grant_idx_q] = 1'b1;
          last_grant_nxt          = grant_idx_q;
        end
      end
      DELIVER: begin
        up_req_nxt = 1'b0;
      end
      default: begin
        up_req_nxt = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.up_req  = up_req_q;
  assign bus.dn_ack  = dn_ack_q;
  assign bus.dn_dout = dn_dout_q;
  assign grant_idx   = grant_idx_q;
  assign busy        = busy_q;

`ifdef ARB_STATS_EN
  logic [31:0] cnt_q [num_req];

  // Per-requester grant counters, bumped on each entry into DELIVER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array is a small register bank, not a RAM, and must
      // read zero after reset, so every entry is reset explicitly.
      for (int i = 0; i < num_req; i++) cnt_q[i] <= '0;
    end else if (state == WAIT && bus.up_ack) begin
      cnt_q[grant_idx_q] <= cnt_q[grant_idx_q] + 32'd1;
    end
  end

  for (genvar g = 0; g < num_req; g++) begin : g_cnt
    assign grant_count[32*g +: 32] = cnt_q[g];
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Testbench for handshake_rr_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_handshake_rr_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk;
  logic             rst;
  logic [IW-1:0]    grant_idx;
  logic             busy;
  logic [NR*32-1:0] grant_count;

  handshake_rr_arbiter_if #(.data_width(DW), .num_req(NR)) bus ();

  handshake_rr_arbiter #(.data_width(DW), .num_req(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .grant_count (grant_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference model: transaction-level round-robin pointer and grant tallies.
  int model_last;
  int model_cnt [NR];

  function automatic int rr_pick(input logic [NR-1:0] req, input int last);
    for (int k = 1; k <= NR; k++)
      if (req[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR*32-1:0] exp_counts();
    logic [NR*32-1:0] v;
    v = '0;
`ifdef ARB_STATS_EN
    for (int i = 0; i < NR; i++) v[32*i +: 32] = 32'(model_cnt[i]);
`endif
    return v;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    if (i >= 0 && i < NR) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    model_last = NR - 1;
    for (int i = 0; i < NR; i++) model_cnt[i] = 0;
  endtask

  task automatic model_grant(input int g);
    if (g >= 0) begin
      model_last   = g;
      model_cnt[g] = model_cnt[g] + 1;
    end
  endtask

  // Observations from one transaction.
  logic [NR-1:0] ack_seen, ack_after;
  logic [DW-1:0] dout_seen;
  int            idx_seen, ack_cyc;
  bit            hold_ok, upreq_low, timeout;

  // Drives one transaction from IDLE and records what the DUT shows; no
  // judgement is made here. Entered and left on a falling edge.
  task automatic run_txn(input logic [NR-1:0] req, input logic [NR-1:0] req_in_wait,
                         input logic [DW-1:0] data, input int delay, input bit linger);
    int waited;
    ack_seen  = '0;
    ack_after = '0;
    dout_seen = '0;
    idx_seen  = -1;
    ack_cyc   = 0;
    hold_ok   = 1'b1;
    upreq_low = 1'b0;
    timeout   = 1'b0;
    bus.dn_req = req;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.up_req !== 1'b1 && waited < 20);
    if (bus.up_req !== 1'b1) begin
      timeout    = 1'b1;
      bus.dn_req = '0;
      return;
    end
    bus.dn_req = req_in_wait;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      if (!(bus.up_req === 1'b1 && busy === 1'b1 && bus.dn_ack === '0)) hold_ok = 1'b0;
    end
    bus.up_ack = 1'b1;
    bus.up_din = data;
    @(negedge clk);
    ack_seen  = bus.dn_ack;
    dout_seen = bus.dn_dout;
    idx_seen  = int'(grant_idx);
    upreq_low = (bus.up_req === 1'b0);
    ack_cyc   = cyc;
    if (linger) bus.dn_req = '0;
    else        bus.up_ack = 1'b0;
    bus.up_din = $urandom;
    @(negedge clk);
    ack_after = bus.dn_ack;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.dn_req = '0;
    bus.up_ack = 1'b0;
    bus.up_din = '0;
    model_reset();
    #1;
    tests++;
    if ({bus.up_req, bus.dn_ack, bus.dn_dout, busy, grant_idx} !== '0) begin
      fails++;
      $display("FAIL reset_initial: up_req=%b dn_ack=%b dout=%h busy=%b grant=%0d, want all 0",
               bus.up_req, bus.dn_ack, bus.dn_dout, busy, grant_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    // Leave non-zero state behind, then reset between edges.
    run_txn(4'b0100, 4'b0100, 32'h1234_5678, 0, 1'b0);
    model_grant(rr_pick(4'b0100, model_last));
    bus.dn_req = '0;
    tests++;
    if (dout_seen !== 32'h1234_5678 || idx_seen !== 2 || timeout) begin
      fails++;
      $display("FAIL reset_pre_txn: dout=%h grant=%0d timeout=%0b, want 12345678 2 0",
               dout_seen, idx_seen, timeout);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if ({bus.up_req, bus.dn_ack, bus.dn_dout, busy, grant_idx} !== '0 || grant_count !== '0) begin
      fails++;
      $display("FAIL reset_async: up_req=%b dn_ack=%b dout=%h busy=%b grant=%0d cnt=%h, want all 0",
               bus.up_req, bus.dn_ack, bus.dn_dout, busy, grant_idx, grant_count);
    end
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int exp;
    for (int t = 0; t < 8; t++) begin
      exp = rr_pick(4'b1111, model_last);
      run_txn(4'b1111, 4'b1111, DW'(32'hC000 + t), 0, 1'b0);
      tests++;
      if (timeout || idx_seen !== exp || ack_seen !== onehot(exp) || ack_after !== '0
          || dout_seen !== DW'(32'hC000 + t)) begin
        fails++;
        $display("FAIL contention_%0d: grant=%0d ack=%b after=%b dout=%h to=%0b, want grant=%0d ack=%b after=0 dout=%h",
                 t, idx_seen, ack_seen, ack_after, dout_seen, timeout, exp, onehot(exp), DW'(32'hC000 + t));
      end
      model_grant(exp);
    end
    bus.dn_req = '0;
    tests++;
    if (grant_count !== exp_counts()) begin
      fails++;
      $display("FAIL contention_counts: got %h want %h", grant_count, exp_counts());
    end
  endtask

  task automatic test_single();
    int prev_cyc;
    prev_cyc = 0;
    for (int t = 0; t < 3; t++) begin
      run_txn(4'b0010, 4'b0010, DW'(100 + t), 0, 1'b0);
      model_grant(rr_pick(4'b0010, model_last));
      tests++;
      if (timeout || ack_seen !== 4'b0010 || dout_seen !== DW'(100 + t) || idx_seen !== 1) begin
        fails++;
        $display("FAIL single_%0d: ack=%b dout=%0d grant=%0d to=%0b, want 0010 %0d 1",
                 t, ack_seen, dout_seen, idx_seen, timeout, 100 + t);
      end
      if (t > 0) begin
        tests++;
        if (ack_cyc - prev_cyc !== 3) begin
          fails++;
          $display("FAIL single_period_%0d: got %0d cycles, want 3", t, ack_cyc - prev_cyc);
        end
      end
      prev_cyc = ack_cyc;
    end
    bus.dn_req = '0;
    @(negedge clk);
  endtask

  task automatic test_slow_upstream();
    int exp;
    exp = rr_pick(4'b1000, model_last);
    run_txn(4'b1000, 4'b1000, 32'hABCD_0005, 5, 1'b0);
    bus.dn_req = '0;
    tests++;
    if (timeout || !hold_ok || !upreq_low || ack_seen !== onehot(exp)
        || dout_seen !== 32'hABCD_0005 || ack_after !== '0) begin
      fails++;
      $display("FAIL slow_upstream: hold=%0b upreq_low=%0b ack=%b after=%b dout=%h to=%0b, want 1 1 %b 0 abcd0005",
               hold_ok, upreq_low, ack_seen, ack_after, dout_seen, timeout, onehot(exp));
    end
    model_grant(exp);
    @(negedge clk);
  endtask

  task automatic test_dropped();
    int exp;
    // Point the round-robin just before requester 2 so it is granted.
    run_txn(4'b0010, 4'b0010, 32'h1, 0, 1'b0);
    model_grant(rr_pick(4'b0010, model_last));
    exp = rr_pick(4'b0100, model_last);
    run_txn(4'b0100, 4'b0000, 32'h0000_DEAD, 2, 1'b0);
    tests++;
    if (timeout || exp !== 2 || ack_seen !== 4'b0100 || dout_seen !== 32'h0000_DEAD) begin
      fails++;
      $display("FAIL dropped: ack=%b dout=%h to=%0b, want 0100 0000dead", ack_seen, dout_seen, timeout);
    end
    model_grant(exp);
    exp = rr_pick(4'b0101, model_last);
    run_txn(4'b0101, 4'b0000, 32'h0000_BEEF, 0, 1'b0);
    tests++;
    if (timeout || idx_seen !== exp || ack_seen !== onehot(exp)) begin
      fails++;
      $display("FAIL dropped_next: grant=%0d ack=%b, want %0d", idx_seen, ack_seen, exp);
    end
    model_grant(exp);
  endtask

  task automatic test_lingering_ack();
    bit bad;
    run_txn(4'b0001, 4'b0001, 32'h0000_0077, 0, 1'b1);
    model_grant(rr_pick(4'b0001, model_last));
    bad = (ack_after !== '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.dn_ack !== '0 || bus.up_req !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    bus.up_ack = 1'b0;
    tests++;
    if (timeout || bad || ack_seen !== 4'b0001) begin
      fails++;
      $display("FAIL lingering_ack: extra_activity=%0b ack=%b to=%0b, want 0 0001 0", bad, ack_seen, timeout);
    end
  endtask

  task automatic test_mid_reset();
    int waited;
    bit bad;
    bus.dn_req = 4'b0100;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.up_req !== 1'b1 && waited < 20);
    tests++;
    if (bus.up_req !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_grant: up_req=%b after %0d cycles, want 1", bus.up_req, waited);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (bus.up_req !== 1'b0 || busy !== 1'b0 || bus.dn_ack !== '0 || grant_idx !== '0) begin
      fails++;
      $display("FAIL mid_reset_async: up_req=%b busy=%b ack=%b grant=%0d, want 0 0 0 0",
               bus.up_req, busy, bus.dn_ack, grant_idx);
    end
    bus.dn_req = '0;
    @(negedge clk);
    rst = 1'b0;
    bus.up_ack = 1'b1;
    bus.up_din = 32'h0000_0BAD;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.dn_ack !== '0 || bus.up_req !== 1'b0) bad = 1'b1;
    end
    bus.up_ack = 1'b0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL mid_reset_stale_ack: dn_ack=%b up_req=%b, want no delivery", bus.dn_ack, bus.up_req);
    end
    run_txn(4'b0001, 4'b0001, 32'h0000_0042, 0, 1'b0);
    tests++;
    if (timeout || idx_seen !== 0 || ack_seen !== 4'b0001 || dout_seen !== 32'h42) begin
      fails++;
      $display("FAIL mid_reset_regrant: grant=%0d ack=%b dout=%h to=%0b, want 0 0001 42",
               idx_seen, ack_seen, dout_seen, timeout);
    end
    model_grant(rr_pick(4'b0001, model_last));
    bus.dn_req = '0;
  endtask

  task automatic test_random();
    logic [NR-1:0] req, req_w;
    logic [DW-1:0] data;
    int            exp, gap;
    bit            bad;
    for (int t = 0; t < 40; t++) begin
      req   = NR'($urandom_range(1, (1 << NR) - 1));
      req_w = NR'($urandom);
      data  = $urandom;
      exp   = rr_pick(req, model_last);
      run_txn(req, req_w, data, int'($urandom_range(0, 3)), 1'b0);
      tests++;
      if (timeout || idx_seen !== exp || ack_seen !== onehot(exp) || dout_seen !== data || ack_after !== '0) begin
        fails++;
        $display("FAIL random_%0d: req=%b grant=%0d ack=%b dout=%h after=%b to=%0b, want grant=%0d dout=%h",
                 t, req, idx_seen, ack_seen, dout_seen, ack_after, timeout, exp, data);
      end
      model_grant(exp);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        bus.dn_req = '0;
        bad = 1'b0;
        for (int g = 0; g < gap; g++) begin
          bus.up_ack = 1'($urandom);
          @(negedge clk);
          if (bus.dn_ack !== '0 || busy !== 1'b0 || bus.dn_dout !== data) bad = 1'b1;
        end
        bus.up_ack = 1'b0;
        tests++;
        if (bad) begin
          fails++;
          $display("FAIL random_idle_%0d: ack=%b busy=%b dout=%h, want idle holding %h",
                   t, bus.dn_ack, busy, bus.dn_dout, data);
        end
      end
    end
    bus.dn_req = '0;
    tests++;
    if (grant_count !== exp_counts()) begin
      fails++;
      $display("FAIL random_counts: got %h want %h", grant_count, exp_counts());
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_slow_upstream();
    test_dropped();
    test_lingering_ack();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
Round-robin arbiter that shares one upstream req/ack data channel (an async_operator output or producer) among num_req downstream requesters.
Each requester uses the standard req/ack protocol: hold req high, receive a one-cycle ack with data valid in that cycle.
The arbiter issues one upstream request per granted transaction and routes the returned datum to the granted requester only.
It is used wherever a single graph node's output fans out to consumers that must be served one at a time rather than in lockstep.

Parameters:
data_width, 32, width of the data bus.
num_req, 4, number of downstream requesters; legal range 2..16. idx_width = clog2(num_req) is an internal localparam.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
dn_req  input  num_req  per-requester request; bit i is requester i.
dn_ack  output  num_req  per-requester one-cycle acknowledge, one-hot or zero.
dn_dout  output  data_width  shared return data; valid only in a cycle where a dn_ack bit is 1.
up_req  output  1  request to the upstream channel.
up_ack  input  1  upstream acknowledge; up_din is valid in the same cycle.
up_din  input  data_width  upstream data.
grant_idx  output  idx_width  index of the current or last granted requester.
busy  output  1  high whenever the state is not IDLE.
grant_count  output  num_req*32  per-requester grant counters; see Optional Feature.

Behaviour:
- Reset: asynchronous on rst high. Values held while rst is high:
  - state = IDLE; up_req = 0; dn_ack = 0; dn_dout = 0; busy = 0.
  - grant_idx = 0; last_grant = num_req-1, so requester 0 has first priority.
- Reset mid-transaction: the transaction is abandoned and no dn_ack is issued for it. An upstream ack arriving after reset is ignored, because up_ack is only sampled in WAIT.
- All outputs are registered.
- FSM states: IDLE, WAIT, DELIVER.
- IDLE:
  - If dn_req != 0, select the first requester with req set, searching from last_grant+1 upward and wrapping modulo num_req.
  - Register grant_idx and set up_req <= 1; go to WAIT.
  - If dn_req == 0, remain in IDLE.
  - up_ack is ignored in IDLE.
- WAIT:
  - up_req is held at 1.
  - When up_ack == 1: dn_dout <= up_din, up_req <= 0, dn_ack[grant_idx] <= 1, last_grant <= grant_idx; go to DELIVER.
- DELIVER:
  - dn_ack[grant_idx] is high for exactly this cycle; dn_ack <= 0 on exit.
  - Go to IDLE.
  - No new arbitration happens in DELIVER. This gives the granted requester one cycle to drop its req before it is re-evaluated.
- Timing: dn_req first sampled high at edge k in IDLE gives up_req high after edge k. If up_ack arrives in the cycle after edge k, dn_ack is high after edge k+1.
  - Minimum transaction period: 3 cycles (IDLE, WAIT, DELIVER).
  - Maximum throughput: one datum per 3 cycles.
- Dropped request: once a grant is issued, the transaction always completes. If dn_req[grant_idx] falls during WAIT, the datum is still delivered with dn_ack. Upstream data is never lost.
- Simultaneous requests: strictly one grant per transaction, round-robin.
  - Any requester holding req continuously is served within num_req transactions.
- A single active requester is granted back-to-back every 3 cycles.
- dn_dout holds its last value outside ack cycles.
- up_din is sampled only in the WAIT cycle where up_ack == 1.
- A lingering up_ack in DELIVER or IDLE never causes a second delivery.

Optional Feature:
Macro: ARB_STATS_EN.
- Defined: grant_count slice i (bits 32*i+31 : 32*i) increments by 1 on each transition into DELIVER with grant_idx == i. Counters wrap from 0xFFFFFFFF to 0 and reset to 0.
- Undefined: grant_count is driven constant 0 and no counter registers are synthesized.

Test Plan:
- Reset: pulse rst asynchronously between clock edges -> all outputs 0, busy 0, grant_idx 0 before the next rising edge.
- Single requester: dn_req = 4'b0010, upstream acks in the cycle after each up_req with up_din = 100, 101, 102 -> dn_ack = 4'b0010 pulses every 3 cycles; dn_dout = 100, 101, 102; grant_idx = 1.
- Full contention: dn_req = 4'b1111 held, upstream acks immediately -> grant order 0, 1, 2, 3, 0, 1; each dn_ack is one-hot and one cycle wide. With ARB_STATS_EN, each grant_count slice = 2 after 8 transactions.
- Slow upstream: up_ack delayed 5 cycles -> up_req stays high 5 cycles, busy stays 1, no dn_ack until the cycle after up_ack, data = up_din at ack.
- Dropped request: requester 2 granted, drops req in WAIT, up_ack with up_din = 0xDEAD -> dn_ack[2] pulses with dn_dout = 0xDEAD; next grant skips 2.
- Mid-transaction reset: assert rst while in WAIT, then release; up_ack = 1 arrives in IDLE -> no dn_ack; a later dn_req = 4'b0001 is granted to requester 0.
